frame_dispatch_fifo: RTL and testbench

FRAME_DISPATCH_FIFO -- requirements
Module: frame_dispatch_fifo

---
 rtl/frame_dispatch_if.sv | 36 +++
 rtl/frame_dispatch_fifo.sv | 169 ++++++++++++++++
 tb/tb_frame_dispatch_fifo.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_dispatch_if.sv
// Frame dispatch bus: frame intake and per-channel
// register transaction outputs.
interface frame_dispatch_if #(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int FRAME_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
);
  logic                             frame_valid;
  logic                             frame_ready;
  logic [NUM_SW_INST-1:0]           load_in;
  logic [FRAME_WIDTH-1:0]           frame_in;
  logic [NUM_SW_INST-1:0]           sel_ack;
  logic [NUM_SW_INST-1:0]           sel_en;
  logic [7:0]                       addr;
  logic [W_WIDTH-1:0]               wr_data;
  logic                             wr_rd_s;
  logic [7:0]                       op_id;
  logic                             err_load;
  logic                             timeout;
  logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level;

  modport master (
    output frame_valid, load_in, frame_in, sel_ack,
    input  frame_ready, sel_en, addr, wr_data,
    input  wr_rd_s, op_id, err_load, timeout,
    input  fifo_level
  );

  modport slave (
    input  frame_valid, load_in, frame_in, sel_ack,
    output frame_ready, sel_en, addr, wr_data,
    output wr_rd_s, op_id, err_load, timeout,
    output fifo_level
  );
endinterface

// File: rtl/frame_dispatch_fifo.sv
// Buffers decoded frames and issues them one at a
// time as register transactions on a selected channel.
module frame_dispatch_fifo #(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int ADDR_W      = 5,
  parameter int FRAME_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input logic clk,
  input logic rst,
  frame_dispatch_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int CW = (TIMEOUT_CYC > 0) ?
                      $clog2(TIMEOUT_CYC+1) : 1;
  localparam int N  = NUM_SW_INST;

  typedef struct packed {
    logic [N-1:0]       sel;
    logic [7:0]         addr;
    logic [W_WIDTH-1:0] data;
    logic               wr;
    logic [7:0]         id;
  } entry_t;

  typedef enum logic {IDLE, BUSY} state_t;

  entry_t          mem [FIFO_DEPTH];
  entry_t          din;
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic [CW-1:0]   cnt;
  state_t          state;
  state_t          next_state;

  logic            full;
  logic            empty;
  logic            one_hot;
  logic            accept;
  logic            push;
  logic            pop;
  logic            hit;
  logic            expire;
  logic            done;
  logic            unused_frame;

  logic [N-1:0]       sel_q;
  logic [7:0]         addr_q;
  logic [W_WIDTH-1:0] data_q;
  logic               wr_q;
  logic [7:0]         id_q;
  logic               err_q;
  logic               to_q;

  assign full   = (level == LW'(FIFO_DEPTH));
  assign empty  = (level == '0);
  assign one_hot = (bus.load_in != '0) &&
    ((bus.load_in & (bus.load_in - N'(1))) == '0);
  assign accept = bus.frame_valid && bus.frame_ready;
  assign push   = accept && one_hot;
  assign head   = mem[rd_ptr];
  assign hit    = |(bus.sel_ack & sel_q);

  // Upper frame bits carry nothing for this block.
  assign unused_frame = ^bus.frame_in;

  assign bus.frame_ready = !rst && !full;
  assign bus.sel_en      = sel_q;
  assign bus.addr        = addr_q;
  assign bus.wr_data     = data_q;
  assign bus.wr_rd_s     = wr_q;
  assign bus.op_id       = id_q;
  assign bus.err_load    = err_q;
  assign bus.timeout     = to_q;
  assign bus.fifo_level  = level;

  // Decode the incoming frame into a buffer entry.
  always_comb begin
    din      = '0;
    din.sel  = bus.load_in;
    din.id   = bus.frame_in[7:0];
    din.data = bus.frame_in[8 +: W_WIDTH];
    din.wr   = bus.frame_in[8+W_WIDTH];
    din.addr = 8'(bus.frame_in[9+W_WIDTH +: ADDR_W]);
  end

  // Next state: pop when idle or when the active
  // transaction completes by ack or timeout.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    expire     = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        expire = (TIMEOUT_CYC > 0) && !hit &&
                 (cnt == CW'(TIMEOUT_CYC-1));
        done   = hit || expire;
        if (done) begin
          if (!empty) pop = 1'b1;
          else next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Buffer storage; pointers qualify its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // FSM state, transaction outputs, wait counter
  // and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
      id_q   <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      state <= next_state;
      err_q <= accept && !one_hot;
      to_q  <= expire;
      if (pop) begin
        sel_q  <= head.sel;
        addr_q <= head.addr;
        data_q <= head.data;
        wr_q   <= head.wr;
        id_q   <= head.id;
        cnt    <= '0;
      end else if (done) begin
        sel_q <= '0;
        cnt   <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_frame_dispatch_fifo.sv
// Bench for frame_dispatch_fifo: vector table,
// directed corner sequences and random traffic.
module tb_frame_dispatch_fifo;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  frame_dispatch_if #(
    .NUM_SW_INST(5), .W_WIDTH(8),
    .FRAME_WIDTH(32), .FIFO_DEPTH(4)
  ) bus ();

  frame_dispatch_fifo dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] mk(input int k);
    logic [7:0] d;
    logic [7:0] i;
    d = 8'hA0 + 8'(k);
    i = 8'h10 + 8'(k);
    return {10'b0, 5'(k), 1'(k & 1), d, i};
  endfunction

  function automatic logic [4:0] ld(input int k);
    return 5'(1 << (k % 5));
  endfunction

  // Reference model: a queue of pending transactions
  // and the one currently on the channel.
  typedef struct {
    logic [4:0] sel;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] id;
    logic       wr;
  } ent_t;

  ent_t       q[$];
  bit         active = 0;
  int         waited = 0;
  logic [4:0] m_sel  = '0;
  logic [7:0] m_addr = '0;
  logic [7:0] m_data = '0;
  logic [7:0] m_id   = '0;
  logic       m_wr   = 1'b0;
  logic       m_err  = 1'b0;
  logic       m_to   = 1'b0;

  always @(posedge clk) begin
    bit   acc;
    bit   fin;
    ent_t e;
    if (rst) begin
      q.delete();
      active = 0; waited = 0;
      m_sel = '0; m_addr = '0; m_data = '0;
      m_id = '0; m_wr = 1'b0;
      m_err = 1'b0; m_to = 1'b0;
    end else begin
      acc   = bus.frame_valid && (q.size() < 4);
      m_err = acc && ($countones(bus.load_in) != 1);
      m_to  = 1'b0;
      fin   = 0;
      if (active) begin
        if ((bus.sel_ack & m_sel) != 0) fin = 1;
        else if (waited + 1 == 16) begin
          fin = 1; m_to = 1'b1;
        end else waited++;
      end
      if (!active || fin) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          m_sel = e.sel; m_addr = e.addr;
          m_data = e.data; m_id = e.id; m_wr = e.wr;
          active = 1; waited = 0;
        end else if (fin) begin
          m_sel = '0; active = 0;
        end
      end
      if (acc && $countones(bus.load_in) == 1) begin
        e.sel  = bus.load_in;
        e.addr = {3'b0, bus.frame_in[21:17]};
        e.wr   = bus.frame_in[16];
        e.data = bus.frame_in[15:8];
        e.id   = bus.frame_in[7:0];
        q.push_back(e);
      end
    end
    #1;
    check("model_sel", bus.sel_en, m_sel);
    check("model_addr", bus.addr, m_addr);
    check("model_data", bus.wr_data, m_data);
    check("model_wr", bus.wr_rd_s, m_wr);
    check("model_id", bus.op_id, m_id);
    check("model_err", bus.err_load, m_err);
    check("model_to", bus.timeout, m_to);
    check("model_level", bus.fifo_level, q.size());
    check("model_ready", bus.frame_ready,
          !rst && q.size() < 4);
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.frame_valid = 1'b0;
    bus.sel_ack = '0;
    step();
    step();
    check("ready_in_rst", bus.frame_ready, 0);
    check("rst_sel", bus.sel_en, 0);
    check("rst_level", bus.fifo_level, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", bus.frame_ready, 1);
  endtask

  task automatic push_frame(input int k);
    bit pre;
    bit got;
    got = 0;
    bus.frame_valid = 1'b1;
    bus.frame_in = mk(k);
    bus.load_in = ld(k);
    for (int t = 0; t < 40 && !got; t++) begin
      pre = bus.frame_ready;
      step();
      if (pre) got = 1;
    end
    bus.frame_valid = 1'b0;
    check("push_accepted", got, 1);
  endtask

  typedef struct {
    logic [31:0] frame;
    logic [4:0]  load;
    logic        err;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [7:0]  id;
    logic        wr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit pre;
    int r;
    tbl[0] = '{32'h003A5C42, 5'b00100, 1'b0,
               8'h1D, 8'h5C, 8'h42, 1'b0};
    tbl[1] = '{32'hFFFFFFFF, 5'b00001, 1'b0,
               8'h1F, 8'hFF, 8'hFF, 1'b1};
    tbl[2] = '{32'h00010000, 5'b10000, 1'b0,
               8'h00, 8'h00, 8'h00, 1'b1};
    tbl[3] = '{32'hFFC00000, 5'b01000, 1'b0,
               8'h00, 8'h00, 8'h00, 1'b0};
    tbl[4] = '{32'h0024A501, 5'b00010, 1'b0,
               8'h12, 8'hA5, 8'h01, 1'b0};
    tbl[5] = '{32'h12345678, 5'b00110, 1'b1,
               8'h00, 8'h00, 8'h00, 1'b0};
    tbl[6] = '{32'h12345678, 5'b00000, 1'b1,
               8'h00, 8'h00, 8'h00, 1'b0};
    tbl[7] = '{32'h0000FFFF, 5'b11111, 1'b1,
               8'h00, 8'h00, 8'h00, 1'b0};

    rst = 1'b1;
    bus.frame_valid = 1'b0;
    bus.load_in = '0;
    bus.frame_in = '0;
    bus.sel_ack = '0;
    do_reset();

    // Single-frame decode and illegal-load drop.
    for (int i = 0; i < 8; i++) begin
      bus.frame_valid = 1'b1;
      bus.frame_in = tbl[i].frame;
      bus.load_in = tbl[i].load;
      step();
      bus.frame_valid = 1'b0;
      check("tbl_err", bus.err_load, tbl[i].err);
      check("tbl_level1", bus.fifo_level, !tbl[i].err);
      check("tbl_sel_early", bus.sel_en, 0);
      step();
      check("tbl_err_once", bus.err_load, 0);
      check("tbl_level2", bus.fifo_level, 0);
      if (tbl[i].err) begin
        check("tbl_drop_sel", bus.sel_en, 0);
      end else begin
        check("tbl_sel", bus.sel_en, tbl[i].load);
        check("tbl_addr", bus.addr, tbl[i].addr);
        check("tbl_data", bus.wr_data, tbl[i].data);
        check("tbl_wr", bus.wr_rd_s, tbl[i].wr);
        check("tbl_id", bus.op_id, tbl[i].id);
        bus.sel_ack = tbl[i].load;
        step();
        bus.sel_ack = '0;
        check("tbl_ack_sel", bus.sel_en, 0);
        check("tbl_ack_hold", bus.op_id, tbl[i].id);
      end
    end

    // Fill to full with one transaction active.
    do_reset();
    for (int k = 0; k < 5; k++) push_frame(k);
    check("full_level", bus.fifo_level, 4);
    check("full_ready", bus.frame_ready, 0);
    check("full_sel", bus.sel_en, ld(0));
    check("full_id", bus.op_id, 8'h10);
    bus.frame_valid = 1'b1;
    bus.frame_in = mk(5);
    bus.load_in = ld(5);
    for (int s = 0; s < 3; s++) begin
      step();
      check("stall_ready", bus.frame_ready, 0);
      check("stall_level", bus.fifo_level, 4);
    end
    bus.sel_ack = ~bus.sel_en;
    step();
    check("nosel_ack_sel", bus.sel_en, ld(0));
    check("nosel_ack_id", bus.op_id, 8'h10);
    for (int j = 1; j <= 6; j++) begin
      bus.sel_ack = bus.sel_en;
      pre = bus.frame_ready;
      step();
      if (pre) bus.frame_valid = 1'b0;
      if (j <= 5) begin
        check("b2b_sel", bus.sel_en, ld(j));
        check("b2b_id", bus.op_id, 8'h10 + 8'(j));
      end else begin
        check("b2b_end_sel", bus.sel_en, 0);
        check("b2b_end_id", bus.op_id, 8'h15);
      end
    end
    bus.sel_ack = '0;
    bus.frame_valid = 1'b0;

    // Timeout, then ack arriving on the last cycle.
    do_reset();
    push_frame(0);
    push_frame(1);
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i < 16) begin
        check("to_quiet", bus.timeout, 0);
        check("to_hold_id", bus.op_id, 8'h10);
      end else begin
        check("to_pulse", bus.timeout, 1);
        check("to_next_id", bus.op_id, 8'h11);
        check("to_next_sel", bus.sel_en, ld(1));
      end
    end
    step();
    check("to_single", bus.timeout, 0);
    for (int i = 0; i < 14; i++) step();
    check("ack16_pre", bus.timeout, 0);
    check("ack16_pre_sel", bus.sel_en, ld(1));
    bus.sel_ack = bus.sel_en;
    step();
    bus.sel_ack = '0;
    check("ack16_no_to", bus.timeout, 0);
    check("ack16_sel", bus.sel_en, 0);
    step();
    check("ack16_after", bus.timeout, 0);

    // Reset in the middle of a busy burst.
    do_reset();
    for (int k = 0; k < 4; k++) push_frame(k);
    check("mid_level", bus.fifo_level, 3);
    check("mid_sel", bus.sel_en, ld(0));
    rst = 1'b1;
    step();
    check("mid_rst_sel", bus.sel_en, 0);
    check("mid_rst_addr", bus.addr, 0);
    check("mid_rst_data", bus.wr_data, 0);
    check("mid_rst_wr", bus.wr_rd_s, 0);
    check("mid_rst_id", bus.op_id, 0);
    check("mid_rst_level", bus.fifo_level, 0);
    check("mid_rst_err", bus.err_load, 0);
    check("mid_rst_to", bus.timeout, 0);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", bus.frame_ready, 1);

    // Random traffic against the model.
    step();
    for (int c = 0; c < 600; c++) begin
      bus.frame_valid = 1'($urandom_range(0, 1));
      bus.frame_in = $urandom;
      if ($urandom_range(0, 99) < 75)
        bus.load_in = 5'(1 << $urandom_range(0, 4));
      else
        bus.load_in = 5'($urandom);
      r = $urandom_range(0, 99);
      if (r < 15) bus.sel_ack = bus.sel_en;
      else if (r < 30) bus.sel_ack = 5'($urandom);
      else bus.sel_ack = '0;
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    bus.frame_valid = 1'b0;
    bus.sel_ack = '0;
    step();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
endmodule
